// File: rtl/keypad_event_capture.sv
// Qualifies key presses from the scanner's ASCII decode stream, emits one event per
// press, and buffers events in a 4-deep FIFO with a valid/ready output handshake.
module keypad_event_capture #(
    parameter int STABLE_CYCLES  = 500,
    parameter int RELEASE_CYCLES = 5000,
    parameter int CNT_W          = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] decode,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_code,
    output logic       key_held,
    output logic       overflow
);

    localparam logic [CNT_W-1:0] STABLE_LIM  = CNT_W'(STABLE_CYCLES);
    localparam logic [CNT_W-1:0] RELEASE_LIM = CNT_W'(RELEASE_CYCLES);
    localparam logic [7:0]       NO_KEY      = 8'h3F;

    typedef enum logic [1:0] {IDLE, QUAL, HELD} state_t;

    function automatic logic is_key(input logic [7:0] c);
        return ((c >= 8'h30) && (c <= 8'h39)) || ((c >= 8'h41) && (c <= 8'h46));
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_t           state;
    logic [7:0]       dec_q;
    logic [7:0]       cand;
    logic [CNT_W-1:0] qcnt;
    logic [CNT_W-1:0] rcnt;
    logic             key_valid;
    logic             push;
    logic             cand_load;

    logic [7:0]       mem [0:3];
    logic [1:0]       wr;
    logic [1:0]       rd;
    logic [2:0]       count;
    logic             pop;
    logic             full;
    logic             do_write;

    assign key_valid = is_key(dec_q);
    assign cand_load = key_valid && ((state == IDLE) || ((state == QUAL) && (dec_q != cand)));
    // A press qualifies on the sample that brings qcnt up to STABLE_CYCLES.
    assign push      = (state == QUAL) && key_valid && (dec_q == cand) &&
                       (sat_inc(qcnt) >= STABLE_LIM);

    always_ff @(posedge clk) begin
        if (cand_load) begin
            cand <= dec_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dec_q    <= NO_KEY;
            qcnt     <= '0;
            rcnt     <= '0;
            key_held <= 1'b0;
        end else begin
            dec_q <= decode;
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        state <= QUAL;
                        qcnt  <= CNT_W'(1);
                    end
                end
                QUAL: begin
                    if (!key_valid) begin
                        state <= IDLE;
                        qcnt  <= '0;
                    end else if (dec_q != cand) begin
                        qcnt <= CNT_W'(1);
                    end else if (push) begin
                        state    <= HELD;
                        key_held <= 1'b1;
                        qcnt     <= '0;
                        rcnt     <= '0;
                    end else begin
                        qcnt <= sat_inc(qcnt);
                    end
                end
                HELD: begin
                    // Any key, even a different one, keeps the press alive.
                    if (key_valid) begin
                        rcnt <= '0;
                    end else if (sat_inc(rcnt) >= RELEASE_LIM) begin
                        state    <= IDLE;
                        key_held <= 1'b0;
                        rcnt     <= '0;
                    end else begin
                        rcnt <= sat_inc(rcnt);
                    end
                end
                default: begin
                    state    <= IDLE;
                    key_held <= 1'b0;
                    qcnt     <= '0;
                    rcnt     <= '0;
                end
            endcase
        end
    end

    assign out_valid = (count != 3'd0);
    assign out_code  = out_valid ? mem[rd] : NO_KEY;
    assign pop       = out_valid && out_ready;
    assign full      = (count == 3'd4);
    // When full, a simultaneous pop frees the slot the write lands in.
    assign do_write  = push && (!full || pop);

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr] <= cand;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr       <= '0;
            rd       <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (do_write) begin
                wr <= wr + 2'd1;
            end
            if (pop) begin
                rd <= rd + 2'd1;
            end
            if (do_write && !pop) begin
                count <= count + 3'd1;
            end else if (!do_write && pop) begin
                count <= count - 3'd1;
            end
            if (push && full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_keypad_event_capture.sv
// Directed bench for keypad_event_capture with STABLE_CYCLES=4, RELEASE_CYCLES=16.
module tb_keypad_event_capture;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] decode;
    logic       out_ready;
    logic       out_valid;
    logic [7:0] out_code;
    logic       key_held;
    logic       overflow;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] got [0:7];
    int         n_got;

    keypad_event_capture #(
        .STABLE_CYCLES (4),
        .RELEASE_CYCLES(16),
        .CNT_W         (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .decode   (decode),
        .out_ready(out_ready),
        .out_valid(out_valid),
        .out_code (out_code),
        .key_held (key_held),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors so far %0d", errors);
        $fatal(1);
    end

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic cyc(input logic [7:0] d, input logic rdy);
        decode    = d;
        out_ready = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic press(input logic [7:0] k);
        repeat (6) cyc(k, 1'b0);
        repeat (20) cyc(8'h3F, 1'b0);
    endtask

    task automatic drain();
        n_got = 0;
        while (out_valid && n_got < 8) begin
            got[n_got] = out_code;
            n_got++;
            cyc(8'h3F, 1'b1);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; decode = 8'h3F; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        checks++; if (out_code !== 8'h3F) begin errors++; $display("FAIL reset_code: got %h expected 3f", out_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held: got %b expected 0", key_held); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
        reset = 1'b0;
        repeat (3) cyc(8'h3F, 1'b1);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL empty_pop_valid: got %b expected 0", out_valid); end
        checks++; if (out_code !== 8'h3F) begin errors++; $display("FAIL empty_pop_code: got %h expected 3f", out_code); end
        out_ready = 1'b0;
    endtask

    task automatic test_single_press();
        for (int i = 1; i <= 10; i++) begin
            cyc(8'h35, 1'b0);
            if (i == 4) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t1_early_valid: got %b expected 0", out_valid); end
            end
            if (i == 5) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t1_valid_edge4: got %b expected 1", out_valid); end
                checks++; if (out_code !== 8'h35) begin errors++; $display("FAIL t1_code: got %h expected 35", out_code); end
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL t1_held: got %b expected 1", key_held); end
            end
        end
        for (int j = 1; j <= 20; j++) begin
            cyc(8'h3F, 1'b0);
            if (j == 16) begin
                checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL t1_held_before_release: got %b expected 1", key_held); end
            end
            if (j == 17) begin
                checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL t1_release: got %b expected 0", key_held); end
            end
        end
        drain();
        checks++; if (n_got !== 1) begin errors++; $display("FAIL t1_count: got %0d expected 1", n_got); end
        checks++; if (got[0] !== 8'h35) begin errors++; $display("FAIL t1_event: got %h expected 35", got[0]); end
    endtask

    task automatic test_scan_pattern();
        for (int r = 0; r < 5; r++) begin
            repeat (6) cyc(8'h37, 1'b0);
            repeat (12) cyc(8'h3F, 1'b0);
            checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL t2_held_gap%0d: got %b expected 1", r, key_held); end
        end
        repeat (20) cyc(8'h3F, 1'b0);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL t2_release: got %b expected 0", key_held); end
        drain();
        checks++; if (n_got !== 1) begin errors++; $display("FAIL t2_count: got %0d expected 1", n_got); end
        checks++; if (got[0] !== 8'h37) begin errors++; $display("FAIL t2_event: got %h expected 37", got[0]); end
    endtask

    task automatic test_bounce();
        logic [7:0] seq [0:4];
        seq = '{8'h33, 8'h3F, 8'h33, 8'h33, 8'h3F};
        for (int i = 0; i < 5; i++) cyc(seq[i], 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t3_bounce_valid: got %b expected 0", out_valid); end
        repeat (5) cyc(8'h33, 1'b0);
        repeat (20) cyc(8'h3F, 1'b0);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL t3_release: got %b expected 0", key_held); end
        drain();
        checks++; if (n_got !== 1) begin errors++; $display("FAIL t3_count: got %0d expected 1", n_got); end
        checks++; if (got[0] !== 8'h33) begin errors++; $display("FAIL t3_event: got %h expected 33", got[0]); end
    endtask

    task automatic test_overflow();
        press(8'h31); press(8'h32); press(8'h33); press(8'h34); press(8'h41);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t4_valid: got %b expected 1", out_valid); end
        checks++; if (out_code !== 8'h31) begin errors++; $display("FAIL t4_head: got %h expected 31", out_code); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf: got %b expected 1", overflow); end
        drain();
        checks++; if (n_got !== 4) begin errors++; $display("FAIL t4_count: got %0d expected 4", n_got); end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (got[i] !== 8'h31 + 8'(i)) begin errors++; $display("FAIL t4_event%0d: got %h expected %h", i, got[i], 8'h31 + 8'(i)); end
        end
        checks++; if (out_code !== 8'h3F) begin errors++; $display("FAIL t4_empty_code: got %h expected 3f", out_code); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf_sticky: got %b expected 1", overflow); end
    endtask

    task automatic test_full_push_pop();
        reset = 1'b1;
        cyc(8'h3F, 1'b0);
        reset = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t5_ovf_cleared: got %b expected 0", overflow); end
        press(8'h31); press(8'h32); press(8'h33); press(8'h34);
        repeat (4) cyc(8'h42, 1'b0);
        cyc(8'h42, 1'b1);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t5_valid: got %b expected 1", out_valid); end
        checks++; if (out_code !== 8'h32) begin errors++; $display("FAIL t5_head: got %h expected 32", out_code); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL t5_ovf: got %b expected 0", overflow); end
        cyc(8'h42, 1'b0);
        repeat (20) cyc(8'h3F, 1'b0);
        drain();
        checks++; if (n_got !== 4) begin errors++; $display("FAIL t5_count: got %0d expected 4", n_got); end
        checks++; if (got[0] !== 8'h32) begin errors++; $display("FAIL t5_e0: got %h expected 32", got[0]); end
        checks++; if (got[2] !== 8'h34) begin errors++; $display("FAIL t5_e2: got %h expected 34", got[2]); end
        checks++; if (got[3] !== 8'h42) begin errors++; $display("FAIL t5_tail: got %h expected 42", got[3]); end
    endtask

    task automatic test_reset_mid();
        press(8'h35); press(8'h36);
        repeat (3) cyc(8'h39, 1'b0);
        reset = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_async_valid: got %b expected 0", out_valid); end
        checks++; if (out_code !== 8'h3F) begin errors++; $display("FAIL t6_async_code: got %h expected 3f", out_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL t6_async_held: got %b expected 0", key_held); end
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            cyc(8'h39, 1'b0);
            if (i == 4) begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL t6_early_valid: got %b expected 0", out_valid); end
            end
            if (i == 5) begin
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL t6_valid: got %b expected 1", out_valid); end
                checks++; if (out_code !== 8'h39) begin errors++; $display("FAIL t6_code: got %h expected 39", out_code); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_press();
        test_scan_pattern();
        test_bounce();
        test_overflow();
        test_full_push_pop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
